// File: rtl/mux_8_to_1_pkg.sv
// Shared constants and select type for the registered 8:1 multiplexer.
package mux_8_to_1_pkg;
   localparam int NUM_IN        = 8;
   localparam int SEL_W         = 3;
   localparam int DEFAULT_WIDTH = 1;

   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_8_to_1_core.sv
// Purely combinational 8:1 select; every select code maps to exactly one input.
module mux_8_to_1_core
   import mux_8_to_1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  sel_t             i_sel,
   input  logic [WIDTH-1:0] i_d0,
   input  logic [WIDTH-1:0] i_d1,
   input  logic [WIDTH-1:0] i_d2,
   input  logic [WIDTH-1:0] i_d3,
   input  logic [WIDTH-1:0] i_d4,
   input  logic [WIDTH-1:0] i_d5,
   input  logic [WIDTH-1:0] i_d6,
   input  logic [WIDTH-1:0] i_d7,
   output logic [WIDTH-1:0] o_y
);

   // NOTE: all eight codes are listed, so the case is full and no latch is inferred.
   always_comb begin
      case (i_sel)
         3'd0: o_y = i_d0;
         3'd1: o_y = i_d1;
         3'd2: o_y = i_d2;
         3'd3: o_y = i_d3;
         3'd4: o_y = i_d4;
         3'd5: o_y = i_d5;
         3'd6: o_y = i_d6;
         3'd7: o_y = i_d7;
      endcase
   end

endmodule

// File: rtl/mux_8_to_1.sv
// Registered 8:1 multiplexer; define MUX_8_TO_1_IN_REG_EN to add an input
// register stage ahead of the mux (latency 2 instead of 1).
module mux_8_to_1
   import mux_8_to_1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   input  logic [WIDTH-1:0] i5,
   input  logic [WIDTH-1:0] i6,
   input  logic [WIDTH-1:0] i7,
   output logic [WIDTH-1:0] o
);

   sel_t             w_sel;
   logic [WIDTH-1:0] w_din [NUM_IN];
   logic [WIDTH-1:0] w_mux;
   logic [WIDTH-1:0] r_o;

`ifdef MUX_8_TO_1_IN_REG_EN
   sel_t             r_sel;
   logic [WIDTH-1:0] r_din [NUM_IN];

   // A cleared input stage selects i0 holding 0, so o stays 0 after release.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel <= '0;
         for (int k = 0; k < NUM_IN; k++) r_din[k] <= '0;
      end else begin
         r_sel    <= {s2, s1, s0};
         r_din[0] <= i0;
         r_din[1] <= i1;
         r_din[2] <= i2;
         r_din[3] <= i3;
         r_din[4] <= i4;
         r_din[5] <= i5;
         r_din[6] <= i6;
         r_din[7] <= i7;
      end
   end

   assign w_sel = r_sel;
   assign w_din = r_din;
`else
   assign w_sel = {s2, s1, s0};
   assign w_din = '{i0, i1, i2, i3, i4, i5, i6, i7};
`endif

   mux_8_to_1_core #(.WIDTH(WIDTH)) u_core (
      .i_sel (w_sel),
      .i_d0  (w_din[0]),
      .i_d1  (w_din[1]),
      .i_d2  (w_din[2]),
      .i_d3  (w_din[3]),
      .i_d4  (w_din[4]),
      .i_d5  (w_din[5]),
      .i_d6  (w_din[6]),
      .i_d7  (w_din[7]),
      .o_y   (w_mux)
   );

   // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_o <= '0;
      else     r_o <= w_mux;
   end

   assign o = r_o;

endmodule

// File: tb/tb_mux_8_to_1.sv
// Self-checking bench for mux_8_to_1 (WIDTH = 8): directed steps followed by
// random traffic, checked every cycle against a history-based reference model.
module tb_mux_8_to_1;

`ifdef MUX_8_TO_1_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
   logic [W-1:0] din [8];
   logic [W-1:0] o;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-edge record of what the DUT sampled: reset flag and the selected data.
   logic         hist_rst [$];
   logic [W-1:0] hist_val [$];

   always #5 clk = ~clk;

   mux_8_to_1 #(.WIDTH(W)) dut (
      .clk (clk), .rst (rst),
      .s0 (s0), .s1 (s1), .s2 (s2),
      .i0 (din[0]), .i1 (din[1]), .i2 (din[2]), .i3 (din[3]),
      .i4 (din[4]), .i5 (din[5]), .i6 (din[6]), .i7 (din[7]),
      .o (o)
   );

   // o after edge k is 0 if any of the last LAT edges saw reset (missing
   // history counts as reset), otherwise the data selected LAT-1 edges earlier.
   function automatic logic [W-1:0] model_o();
      int n = hist_rst.size();
      for (int j = 0; j < LAT; j++) begin
         if (n - 1 - j < 0) return '0;
         if (hist_rst[n-1-j]) return '0;
      end
      return hist_val[n-LAT];
   endfunction

   task automatic check(input string tag);
      logic [W-1:0] exp_o = model_o();
      n_cmp++;
      assert (o === exp_o)
      else begin
         n_bad++;
         $error("FAIL %s: o=%h expected %h", tag, o, exp_o);
      end
   endtask

   task automatic step(input logic r, input logic [2:0] sel, input string tag);
      rst = r;
      {s2, s1, s0} = sel;
      @(posedge clk);
      hist_rst.push_back(r);
      hist_val.push_back(din[sel]);
      #1;
      check(tag);
   endtask

   task automatic set_all(input logic [W-1:0] v);
      for (int k = 0; k < 8; k++) din[k] = v;
   endtask

   initial begin
      logic [2:0] sw;

      // Reset held two edges with busy inputs.
      set_all(8'h01);
      step(1'b1, 3'd5, "reset0");
      step(1'b1, 3'd5, "reset1");

      // Alternating sweep; s0 listed as the slowest-changing bit.
      for (int k = 0; k < 8; k++) din[k] = (k % 2 == 1) ? 8'h01 : 8'h00;
      for (int k = 0; k < 8; k++) begin
         sw = 3'(k);
         step(1'b0, {sw[0], sw[1], sw[2]}, "sweep");
      end
      step(1'b0, 3'd7, "sweep_tail");

      // Walking one, selected and neighbour.
      for (int n = 0; n < 8; n++) begin
         set_all(8'h00);
         din[n] = 8'hFF;
         step(1'b0, 3'(n), "walk_hit");
         step(1'b0, 3'((n + 1) % 8), "walk_miss");
      end

      // Select and data change at the same edge.
      set_all(8'h00);
      step(1'b0, 3'd2, "same_edge_pre");
      din[6] = 8'h01;
      step(1'b0, 3'd6, "same_edge");
      step(1'b0, 3'd6, "same_edge_hold");

      // Mid-run reset with o = 1 beforehand.
      set_all(8'h00);
      din[7] = 8'h01;
      step(1'b0, 3'd7, "midrst_pre0");
      step(1'b0, 3'd7, "midrst_pre1");
      step(1'b1, 3'd7, "midrst");
      step(1'b0, 3'd7, "midrst_rel0");
      step(1'b0, 3'd7, "midrst_rel1");

      // Full-width pattern.
      set_all(8'h00);
      din[3] = 8'hA5;
      step(1'b0, 3'd3, "width0");
      step(1'b0, 3'd3, "width1");

      // Random traffic with occasional resets.
      for (int t = 0; t < 200; t++) begin
         for (int k = 0; k < 8; k++) din[k] = W'($urandom);
         step(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_8_to_1.md
# mux_8_to_1

Registered 8-to-1 multiplexer. Three select bits choose one of eight data inputs, and the chosen value is registered onto `o` on the rising clock edge. It sits in the datapath wherever one of eight equal-width sources feeds a single clocked consumer. The output is deterministic from reset onward.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of each data input and of `o`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous, active-high reset.
- `s0`  input  1  select bit 0 (LSB).
- `s1`  input  1  select bit 1.
- `s2`  input  1  select bit 2 (MSB).
- `i0` … `i7`  input  WIDTH each  data inputs, indexed 0..7.
- `o`  output  WIDTH  registered selected data.

## Operation
- Select index `sel = {s2, s1, s0}`, range 0..7.
- All eight codes are decoded explicitly:
  - `sel = n` selects `in` (0 → `i0`, 1 → `i1`, …, 7 → `i7`).
  - There is no unused code and no default-to-zero path for valid codes.
- Selection is bitwise-uniform across WIDTH; there is no arithmetic and no width conversion.
- The combinational select result is captured into the output register each clock.
- No enable; the register updates on every cycle that is not in reset.
- Behaviour on X/Z select is not guaranteed and is not checked.

## Timing
- Reset value: `o = {WIDTH{1'b0}}`.
- Reset is sampled at the rising `clk` edge only; asserting `rst` between edges has no effect until the next edge.
- `rst` has priority over data: any edge with `rst = 1` loads 0, whatever the select and data values.
- Latency, base build: 1 cycle. Inputs sampled at edge k appear on `o` after edge k.
- A select change and a data change in the same cycle are both honoured at that edge.
- Reset deassertion: the first edge with `rst = 0` loads the selected input.
- Reset mid-stream discards any in-flight value.

## Configuration
- Macro `MUX_8_TO_1_IN_REG_EN`.
- Defined:
  - Adds an input register stage capturing `s0..s2` and `i0..i7` before the mux.
  - Latency becomes 2 cycles.
  - `rst` clears both stages to 0.
  - For 2 cycles after reset release, `o` reflects the cleared input stage, i.e. `i0` with value 0, so `o = 0`.
- Undefined: single output register only; latency is 1 cycle.

## Structure
- Shared package `mux_8_to_1_pkg` holds:
  - `NUM_IN = 8`.
  - `SEL_W = 3`.
  - Default `WIDTH = 1`.
  - Typedef `sel_t` (logic [SEL_W-1:0]).
- One sub-module, `mux_8_to_1_core`: purely combinational 8:1 select on `sel_t` and WIDTH-bit inputs, with no clock.
- The top module instantiates the core and adds the reset-able register stage(s).

## Test plan
Latency below is for the base build. Shift all checks by one cycle when `MUX_8_TO_1_IN_REG_EN` is defined.

1. Reset: hold `rst = 1` for 2 edges with `i0..i7 = 1` and `sel = 5`. Required: `o = 0` after each edge.
2. Sweep with `i0..i7 = 0,1,0,1,0,1,0,1`:
   - Step `{s2,s1,s0}` 0..7, one code per cycle, with (s0,s1,s2) in the order (0,0,0), (0,0,1), (0,1,0), (0,1,1), (1,0,0), (1,0,1), (1,1,0), (1,1,1).
   - Required `o` one cycle later: 0,0,0,0,1,1,1,1 (equals `s0`).
3. Walking one: `in = 1` and all other inputs 0, with `sel = n`, for n = 0..7. Required: `o = 1` for each n. With `sel = (n+1)%8`, required `o = 0`.
4. Same-edge change: switch `sel` from 2 to 6 while `i6` changes from 0 to 1 in the same cycle. Required: `o = 1` after that edge.
5. Mid-run reset: `sel = 7`, `i7 = 1`, `o = 1`; assert `rst` for one edge. Required:
   - `o = 0` after that edge.
   - `o = 1` after the first edge with `rst = 0`.
6. Width: with `WIDTH = 8`, `i3 = 8'hA5`, and `sel = 3`, required `o = 8'hA5`.
